// File: rtl/preg_free_list_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
// Pointers carry one extra wrap bit beyond the array index so full and empty differ.
package preg_free_list_pkg;

    localparam int NUM_PREGS      = 64;
    localparam int NUM_AREGS      = 32;
    localparam int RETIRE_WIDTH   = 2;
    localparam int DISPATCH_WIDTH = 2;
    localparam int ALLOC_WIDTH    = DISPATCH_WIDTH;
    localparam int FL_DEPTH       = NUM_PREGS - NUM_AREGS;
    localparam int PW             = $clog2(NUM_PREGS);
    localparam int IDX_W          = $clog2(FL_DEPTH);
    localparam int PTR_W          = IDX_W + 1;

    typedef logic [PW-1:0]    preg_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Drop the wrap bit to get the array slot a pointer refers to.
    function automatic idx_t ptrIdx(input ptr_t p);
        return idx_t'(p);
    endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/retire-side bundle for the free list: the master drives requests,
// frees, commits and flush; the slave (the free list) answers grants and counts.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic [ALLOC_WIDTH-1:0]  alloc_req;
    preg_t [ALLOC_WIDTH-1:0] alloc_preg;
    logic                    alloc_gnt;
    logic [RETIRE_WIDTH-1:0] free_valid;
    preg_t [RETIRE_WIDTH-1:0] free_preg;
    logic [RETIRE_WIDTH-1:0] commit_alloc;
    logic                    flush;
    ptr_t                    free_count;
    logic                    empty;

    modport master (
        output alloc_req, free_valid, free_preg, commit_alloc, flush,
        input  alloc_preg, alloc_gnt, free_count, empty
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, commit_alloc, flush,
        output alloc_preg, alloc_gnt, free_count, empty
    );

endinterface

// File: rtl/preg_free_list_lane_compact.sv
// Exclusive prefix popcount: each lane learns how many lower lanes are valid,
// which is its offset from the shared pointer; o_total is the full popcount.
module lane_compact #(
    parameter int W  = 2,
    parameter int OW = 2
) (
    input  logic [W-1:0]          i_valid,
    output logic [W-1:0][OW-1:0]  o_offset,
    output logic [OW-1:0]         o_total
);

    always_comb begin : prefixCount
        logic [OW-1:0] acc;
        acc      = '0;
        o_offset = '0;
        for (int l = 0; l < W; l++) begin
            o_offset[l] = acc;
            acc         = acc + OW'(i_valid[l]);
        end
        o_total = acc;
    end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical registers with a speculative allocation head,
// a committed head for one-cycle flush recovery, and a tail fed by retirement.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    preg_free_list_if.slave    fl_bus
);

    preg_t r_fl [FL_DEPTH];
    ptr_t  r_specHead;
    ptr_t  r_commitHead;
    ptr_t  r_tail;
    ptr_t  r_freeCount;

    ptr_t [ALLOC_WIDTH-1:0]  w_allocOfs;
    ptr_t [RETIRE_WIDTH-1:0] w_freeOfs;
    ptr_t w_nReq;
    ptr_t w_nFree;
    ptr_t w_nCommit;
    ptr_t w_avail;
    ptr_t w_specNext;
    ptr_t w_commitNext;
    ptr_t w_tailNext;
    logic w_gnt;

    lane_compact #(.W(ALLOC_WIDTH), .OW(PTR_W)) u_allocCompact (
        .i_valid  (fl_bus.alloc_req),
        .o_offset (w_allocOfs),
        .o_total  (w_nReq)
    );

    lane_compact #(.W(RETIRE_WIDTH), .OW(PTR_W)) u_freeCompact (
        .i_valid  (fl_bus.free_valid),
        .o_offset (w_freeOfs),
        .o_total  (w_nFree)
    );

    // Grant is all-or-nothing; a same-cycle free never counts toward availability.
    always_comb begin
        w_avail      = r_tail - r_specHead;
        w_gnt        = (w_nReq <= w_avail) && !fl_bus.flush && !rst;
        w_nCommit    = ptr_t'($countones(fl_bus.commit_alloc));
        w_commitNext = r_commitHead + w_nCommit;
        w_tailNext   = r_tail + w_nFree;
        if (fl_bus.flush) begin
            w_specNext = w_commitNext;
        end else if (w_gnt) begin
            w_specNext = r_specHead + w_nReq;
        end else begin
            w_specNext = r_specHead;
        end
    end

    always_comb begin
        fl_bus.alloc_preg = '0;
        for (int l = 0; l < ALLOC_WIDTH; l++) begin
            fl_bus.alloc_preg[l] = r_fl[ptrIdx(r_specHead + w_allocOfs[l])];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_specHead   <= '0;
            r_commitHead <= '0;
            r_tail       <= ptr_t'(FL_DEPTH);
            r_freeCount  <= ptr_t'(FL_DEPTH);
        end else begin
            r_specHead   <= w_specNext;
            r_commitHead <= w_commitNext;
            r_tail       <= w_tailNext;
            r_freeCount  <= w_tailNext - w_specNext;
        end
    end

    // At reset the list holds every preg not mapped to an architectural register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fl[i] <= preg_t'(NUM_AREGS + i);
            end
        end else begin
            for (int l = 0; l < RETIRE_WIDTH; l++) begin
                if (fl_bus.free_valid[l]) begin
                    r_fl[ptrIdx(r_tail + w_freeOfs[l])] <= fl_bus.free_preg[l];
                end
            end
        end
    end

    assign fl_bus.alloc_gnt  = w_gnt;
    assign fl_bus.free_count = r_freeCount;
    assign fl_bus.empty      = (r_freeCount == '0);

    a_noOverfree: assert property (@(posedge clk) disable iff (rst)
        ptr_t'(w_tailNext - w_commitNext) <= ptr_t'(FL_DEPTH));

    a_commitBehindSpec: assert property (@(posedge clk) disable iff (rst)
        ptr_t'(w_specNext - w_commitNext) <= ptr_t'(FL_DEPTH));

endmodule

// File: tb/tb_preg_free_list.sv
// Randomized and directed bench for preg_free_list against a queue model of the
// committed free region plus a count of speculatively handed-out entries.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic clk = 1'b0;
    logic rst;

    preg_free_list_if bus ();

    preg_free_list dut (
        .clk    (clk),
        .rst    (rst),
        .fl_bus (bus)
    );

    always #5 clk = ~clk;

    int    vecCount = 0;
    int    errCount = 0;
    int    mq[$];
    int    specOfs;
    logic  lastGnt;
    int    freedOrder[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] fv,
                                 input int fp0, input int fp1,
                                 input logic [1:0] ca, input logic fl);
        bus.alloc_req    = req;
        bus.free_valid   = fv;
        bus.free_preg[0] = preg_t'(fp0);
        bus.free_preg[1] = preg_t'(fp1);
        bus.commit_alloc = ca;
        bus.flush        = fl;
    endtask

    task automatic modelReset();
        mq.delete();
        for (int i = 0; i < FL_DEPTH; i++) mq.push_back(NUM_AREGS + i);
        specOfs = 0;
    endtask

    // Compare outputs with the model; must be called away from the rising edge.
    task automatic checkModel(input string tag);
        int nReq;
        int avail;
        int k;
        nReq    = $countones(bus.alloc_req);
        avail   = mq.size() - specOfs;
        lastGnt = (nReq <= avail) && !bus.flush;
        checkOutput({tag, ".gnt"}, 32'(bus.alloc_gnt), 32'(lastGnt));
        if (lastGnt) begin
            k = 0;
            for (int l = 0; l < ALLOC_WIDTH; l++) begin
                if (bus.alloc_req[l]) begin
                    checkOutput($sformatf("%s.preg%0d", tag, l), 32'(bus.alloc_preg[l]), mq[specOfs + k]);
                    k++;
                end
            end
        end
        checkOutput({tag, ".count"}, 32'(bus.free_count), mq.size() - specOfs);
        checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == specOfs));
    endtask

    task automatic advance();
        int m;
        @(posedge clk);
        if (lastGnt) specOfs += $countones(bus.alloc_req);
        m = $countones(bus.commit_alloc);
        repeat (m) void'(mq.pop_front());
        specOfs -= m;
        if (bus.flush) specOfs = 0;
        for (int l = 0; l < RETIRE_WIDTH; l++) begin
            if (bus.free_valid[l]) mq.push_back(int'(bus.free_preg[l]));
        end
        #1;
    endtask

    task automatic runCycle(input string tag);
        @(negedge clk);
        checkModel(tag);
        advance();
    endtask

    task automatic doReset(input string tag);
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        rst = 1'b1;
        #2;
        checkOutput({tag, ".gnt"}, 32'(bus.alloc_gnt), 0);
        checkOutput({tag, ".count"}, 32'(bus.free_count), FL_DEPTH);
        checkOutput({tag, ".empty"}, 32'(bus.empty), 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] req;
        logic [1:0] fv;
        logic [1:0] ca;
        logic       fl;
        int         fp0;
        int         fp1;
        int         room;

        doReset("rst0");

        // Two lanes from a fresh list get the first two unmapped pregs.
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("first.gnt", 32'(bus.alloc_gnt), 1);
        checkOutput("first.p0", 32'(bus.alloc_preg[0]), 32);
        checkOutput("first.p1", 32'(bus.alloc_preg[1]), 33);
        checkModel("first");
        advance();
        applyStimulus(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("first.count", 32'(bus.free_count), 30);
        checkModel("idle");
        advance();

        repeat (15) begin
            applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
            runCycle("drain");
        end
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("drained.empty", 32'(bus.empty), 1);
        checkOutput("drained.gnt", 32'(bus.alloc_gnt), 0);
        checkModel("drained");
        advance();

        // A free on an empty list is only visible one cycle later.
        applyStimulus(2'b01, 2'b01, 5, 0, 2'b01, 1'b0);
        @(negedge clk);
        checkOutput("nobypass.gnt", 32'(bus.alloc_gnt), 0);
        checkModel("nobypass");
        advance();
        applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("refill.gnt", 32'(bus.alloc_gnt), 1);
        checkOutput("refill.p0", 32'(bus.alloc_preg[0]), 5);
        checkModel("refill");
        advance();

        doReset("rst1");
        applyStimulus(2'b10, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("skip.p1", 32'(bus.alloc_preg[1]), 32);
        checkModel("skip1");
        advance();
        applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("skip.p0", 32'(bus.alloc_preg[0]), 33);
        checkModel("skip0");
        advance();

        doReset("rst2");
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        runCycle("fl.a");
        applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        runCycle("fl.b");
        applyStimulus(2'b00, 2'b00, 0, 0, 2'b01, 1'b0);
        runCycle("fl.c");
        applyStimulus(2'b00, 2'b00, 0, 0, 2'b01, 1'b1);
        runCycle("fl.flush");
        applyStimulus(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("flush.p0", 32'(bus.alloc_preg[0]), 34);
        checkOutput("flush.count", 32'(bus.free_count), 30);
        checkModel("fl.after");
        advance();

        doReset("rst3");
        repeat (16) begin
            applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
            runCycle("wrap.alloc");
        end
        freedOrder.delete();
        repeat (16) begin
            fp0 = $urandom_range(0, NUM_PREGS - 1);
            fp1 = $urandom_range(0, NUM_PREGS - 1);
            freedOrder.push_back(fp0);
            freedOrder.push_back(fp1);
            applyStimulus(2'b00, 2'b11, fp0, fp1, 2'b11, 1'b0);
            runCycle("wrap.free");
        end
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("wrap.p0", 32'(bus.alloc_preg[0]), freedOrder[0]);
        checkOutput("wrap.p1", 32'(bus.alloc_preg[1]), freedOrder[1]);
        checkModel("wrap.re0");
        advance();
        applyStimulus(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("wrap.p2", 32'(bus.alloc_preg[0]), freedOrder[2]);
        checkOutput("wrap.p3", 32'(bus.alloc_preg[1]), freedOrder[3]);
        checkModel("wrap.re1");
        advance();

        // Random traffic, keeping commits and frees within what retirement could legally do.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 700) doReset("midrst");
            req = 2'($urandom_range(0, 3));
            ca  = 2'($urandom_range(0, 3));
            if (specOfs == 0) ca = 2'b00;
            else if (specOfs == 1 && ca == 2'b11) ca = 2'b01;
            fv   = 2'($urandom_range(0, 3));
            room = FL_DEPTH - (mq.size() - $countones(ca));
            if (room <= 0) fv = 2'b00;
            else if (room == 1 && fv == 2'b11) fv = 2'b10;
            fl  = ($urandom_range(0, 15) == 0);
            fp0 = $urandom_range(0, NUM_PREGS - 1);
            fp1 = $urandom_range(0, NUM_PREGS - 1);
            applyStimulus(req, fv, fp0, fp1, ca, fl);
            runCycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list allocator for the rename stage. It hands out up to `ALLOC_WIDTH` free physical registers per cycle to dispatch, and accepts up to `RETIRE_WIDTH` released registers per cycle from the ROB retire logic. It keeps a speculative head and a committed head so that a pipeline flush restores the free list in one cycle. It sits between rename/dispatch and the ROB, and is the sole owner of preg availability.

## Interface
- `NUM_PREGS`, 64, physical register count; preg index width `PW = $clog2(NUM_PREGS)`.
- `NUM_AREGS`, 32, architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset.
- `ALLOC_WIDTH`, 2, allocation lanes per cycle.
- `RETIRE_WIDTH`, 2, free/commit lanes per cycle.
- Derived: `DEPTH = NUM_PREGS-NUM_AREGS` (32); pointer width `$clog2(DEPTH)+1` (extra wrap bit).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alloc_req`  in  ALLOC_WIDTH  per-lane request for one preg.
- `alloc_preg`  out  ALLOC_WIDTH×PW  preg offered to each lane.
- `alloc_gnt`  out  1  all requesting lanes are granted this cycle (all-or-nothing).
- `free_valid`  in  RETIRE_WIDTH  per-lane release of the old preg of a retiring instruction.
- `free_preg`  in  RETIRE_WIDTH×PW  preg being released.
- `commit_alloc`  in  RETIRE_WIDTH  retiring instruction had allocated a preg.
- `flush`  in  1  mispredict/exception recovery.
- `free_count`  out  $clog2(DEPTH)+1  speculative free entries (registered).
- `empty`  out  1  `free_count == 0`.

## Operation
- Storage: circular array `fl[DEPTH]` of PW-bit preg indices; pointers `spec_head`, `commit_head`, `tail`.
- Allocation:
  - `n_req = popcount(alloc_req)`.
  - Requesting lanes, in ascending lane order, receive consecutive entries starting at `spec_head`.
  - Non-requesting lanes are skipped and consume no entry.
  - `alloc_gnt = (n_req <= tail - spec_head) && !flush && !rst`.
  - On grant, `spec_head += n_req`. With no grant, the head is unchanged and all lanes retry.
  - `n_req == 0` gives `alloc_gnt = 1` with no effect.
- Free: valid lanes write `free_preg` at `tail`, `tail+1`, … in lane order; `tail += popcount(free_valid)`.
- Commit: `commit_head += popcount(commit_alloc)`.
- Flush: `spec_head <= commit_head + popcount(commit_alloc)`, including same-cycle commits. Allocation is blocked that cycle. Frees and commits are still processed.
- All pointer arithmetic is modulo 2·DEPTH; the array index is the low `$clog2(DEPTH)` bits.
- Error conditions are assertions only and have no defined RTL behaviour:
  - a free that would make `tail - commit_head > DEPTH`;
  - `commit_head` passing `spec_head`.

## Timing
- Reset values:
  - `fl[i] = NUM_AREGS+i`.
  - `spec_head = commit_head = 0`, `tail = DEPTH`.
  - `free_count = DEPTH`, `empty = 0`.
  - `alloc_gnt = 0` while `rst` is high.
- `alloc_preg` and `alloc_gnt` are combinational from the registered pointers and the array. Dispatch consumes them in the same cycle.
- Freed pregs become allocatable the cycle after `free_valid`. There is no same-cycle bypass, so a free and an alloc in one cycle on an empty list gives `alloc_gnt = 0`.
- `free_count` and `empty` reflect the state after the previous edge.
- Flush takes effect in one cycle; the cycle after flush sees the restored `spec_head`.
- Reset asserted mid-operation returns to the reset image immediately. Any in-flight grants are void.

## Structure
- Shared package constants: `NUM_PREGS`, `NUM_AREGS`, `RETIRE_WIDTH`.
- Add `DISPATCH_WIDTH` (= ALLOC_WIDTH) and `FL_DEPTH` to the shared package.
- Add a `preg_t` typedef (`logic [$clog2(NUM_PREGS)-1:0]`) to the shared package.
- Natural sub-module: `lane_compact`, a prefix-popcount that maps request/free lanes to pointer offsets. It is instantiated twice (alloc and free).

## Test plan
- Reset, then `alloc_req=2'b11` -> `alloc_gnt=1`, `alloc_preg={32,33}`; next cycle `free_count=30`.
- 16 cycles of dual alloc -> `empty=1`; 17th request -> `alloc_gnt=0`, heads unchanged.
- When empty:
  - Free preg 5 and request one alloc in the same cycle -> `gnt=0`.
  - Next cycle -> `gnt=1`, `alloc_preg[0]=5`.
- Lane skipping: `alloc_req=2'b10` at reset -> lane 1 gets 32; following `2'b01` -> lane 0 gets 33.
- Flush recovery:
  - Allocate 32, 33, 34, then commit 1.
  - Flush with `commit_alloc=1` in the same cycle -> next alloc returns 34 and `free_count=30`.
- Wrap-around: allocate all 32, free 32 in pairs, allocate 4 -> pointers wrap and return the freed values in free order; `free_count` is consistent throughout.
